i2s_frame_feature: RTL and testbench
====================================

Name: i2s_frame_feature

Overview:
- Downstream stage of the I2S receiver. Consumes the receiver's left/right sample strobes and works on one selected channel.
- Per sample: removes DC using the previous frame's mean and emits the mean-subtracted stream for later stages (beamformer).
- Per frame of 2^FRAME_LEN_LOG2 samples: reports zero-crossing rate (ZCR), short-time energy (STE) and the frame mean.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- FRAME_LEN_LOG2, 8, log2 of frame length N (256).
- ENERGY_SHIFT, 8, right shift applied to the energy accumulator before output.
- CHANNEL, 0, 0 = use left input, 1 = use right input.

Ports:
- i_sys_clk  in  1  system clock; single clock domain.
- i_sys_rst  in  1  reset, synchronous, active-low.
- i_left_data  in  DATA_WIDTH  left sample from I2S receiver, signed.
- i_right_data  in  DATA_WIDTH  right sample from I2S receiver, signed.
- i_left_vld  in  1  one-cycle strobe, left sample valid.
- i_right_vld  in  1  one-cycle strobe, right sample valid.
- i_clear  in  1  synchronous restart of all frame state.
- o_sample  out  DATA_WIDTH  mean-subtracted sample x', signed.
- o_sample_vld  out  1  one-cycle strobe for o_sample.
- o_zcr  out  FRAME_LEN_LOG2+1  zero crossings in the last frame.
- o_ste  out  2*DATA_WIDTH  energy of the last frame.
- o_mean  out  DATA_WIDTH  mean of the last frame's raw samples, signed.
- o_frame_vld  out  1  one-cycle strobe; o_zcr/o_ste/o_mean updated.

Behaviour:
- Reset (i_sys_rst=0 at a clock edge): all outputs 0. Internal state cleared: mean_prev=0, prev_sign=0 (positive), sample counter=0, accumulators=0, pipeline valids=0.
- Input select: only the CHANNEL input (vld and data) is used; the other channel is ignored. Accepts one sample per cycle, back-to-back.
- Stage 1, edge of acceptance:
  - x' = sat(x - mean_prev), computed at DATA_WIDTH+1 bits, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - o_sample=x'; o_sample_vld=1 for one cycle. Latency 1.
  - raw_sum += x, signed, DATA_WIDTH+FRAME_LEN_LOG2 bits.
- Stage 2:
  - sq = x'*x', unsigned, 2*DATA_WIDTH bits.
  - cross = sign(x') != prev_sign, where sign = MSB and zero counts as positive.
  - prev_sign updates to sign(x'); it carries across frame boundaries.
- Stage 3: energy_acc += sq (2*DATA_WIDTH+FRAME_LEN_LOG2 bits); zcr_acc += cross.
- Frame counter: FRAME_LEN_LOG2 bits, increments per accepted sample, wraps N-1 -> 0. The wrap marks the last sample of the frame.
- Frame close: o_frame_vld pulses 3 cycles after the acceptance edge of sample N. Same edge updates:
  - o_zcr = zcr_acc including sample N.
  - o_ste = min(energy_acc >> ENERGY_SHIFT, 2^(2*DW)-1), saturating.
  - o_mean = raw_sum >>> FRAME_LEN_LOG2, arithmetic shift.
  - mean_prev = the new o_mean.
  - Accumulators restart with whatever sample is in flight, so no samples are lost at full rate.
- mean_prev boundary: becomes effective for the first sample whose stage-1 edge is after that update. Samples accepted during the 3-cycle close window still use the old mean.
- Outputs o_zcr/o_ste/o_mean hold between frame strobes.
- FSM (tracks frame progress, gates o_frame_vld):
  - IDLE -> ACC on the first accepted sample.
  - ACC -> CLOSE on the wrap.
  - CLOSE -> ACC if samples are pending, else IDLE.
- i_clear=1: same effect as reset, except o_zcr/o_ste/o_mean hold their values. Pipeline is flushed. A sample strobe in the same cycle is dropped (clear wins). No o_frame_vld for the partial frame.
- Reset mid-frame: partial frame discarded; no strobe.

Test Plan:
- Reset; FRAME_LEN_LOG2=3, ENERGY_SHIFT=0; hold reset 5 cycles -> all outputs 0, no strobes.
- After reset, left samples +100,-100 alternating x8, CHANNEL=0 -> o_frame_vld once, 3 cycles after the 8th strobe: o_zcr=7, o_ste=80000, o_mean=0. o_sample follows input 1 cycle later.
- After reset, 16 samples of 1000 ->
  - frame 1: zcr=0, ste=8000000, mean=1000.
  - frame 2: o_sample=0 throughout, zcr=0, ste=0, mean=1000.
- After reset, 8x -32768, then 8x +32767 ->
  - frame 1: ste=8589934592, saturates to 0xFFFFFFFF; mean=-32768.
  - frame 2: x' saturates to 32767, zcr=1, ste=0xFFFFFFFF, mean=32767.
- 5 samples, i_clear pulse coincident with a 6th strobe, then the 8-sample alternating set -> exactly one frame strobe; values as scenario 2.
- Right-channel strobes only, with CHANNEL=0 -> no o_sample_vld.
- CHANNEL=1, 16 back-to-back strobes (one per cycle) -> two o_frame_vld pulses exactly 8 cycles apart; no samples dropped.

Source files
------------

// File: rtl/i2s_frame_feature.sv
// i2s_frame_feature: per-channel DC removal plus per-frame ZCR, energy and mean.
// The selected channel's samples go through a 3-stage pipeline:
//   stage 1 subtracts the previous frame's mean (with saturation),
//   stage 2 squares the result and detects sign changes,
//   stage 3 accumulates energy and crossings.
// The frame closes three cycles after the last sample is accepted.
module i2s_frame_feature #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAME_LEN_LOG2 = 8,
  parameter int ENERGY_SHIFT   = 8,
  parameter int CHANNEL        = 0
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst,
  input  logic [DATA_WIDTH-1:0]       i_left_data,
  input  logic [DATA_WIDTH-1:0]       i_right_data,
  input  logic                        i_left_vld,
  input  logic                        i_right_vld,
  input  logic                        i_clear,
  output logic [DATA_WIDTH-1:0]       o_sample,
  output logic                        o_sample_vld,
  output logic [FRAME_LEN_LOG2:0]     o_zcr,
  output logic [2*DATA_WIDTH-1:0]     o_ste,
  output logic [DATA_WIDTH-1:0]       o_mean,
  output logic                        o_frame_vld
);

  localparam int DW = DATA_WIDTH;
  localparam int L  = FRAME_LEN_LOG2;
  localparam int SW = DW + L;        // raw sum width
  localparam int PW = 2 * DW;        // square width
  localparam int EW = 2 * DW + L;    // energy accumulator width
  localparam int ZW = L + 1;         // crossing counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  // Saturating x - m, evaluated one bit wider than the data.
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [DW-1:0] m);
    logic [DW:0] d;
    d = {x[DW-1], x} - {m[DW-1], m};
    if (d[DW] != d[DW-1]) begin
      sat_sub = d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat_sub = d[DW-1:0];
    end
  endfunction

  // Shift the energy accumulator down and clamp it to the output width.
  function automatic logic [PW-1:0] sat_ste(input logic [EW-1:0] acc);
    logic [EW-1:0] sh;
    sh = acc >> ENERGY_SHIFT;
    if (|sh[EW-1:PW]) begin
      sat_ste = {PW{1'b1}};
    end else begin
      sat_ste = sh[PW-1:0];
    end
  endfunction

  // Input selection and frame bookkeeping
  logic          sel_vld_s;
  logic [DW-1:0] sel_data_s;
  logic          acc_s;
  logic          wrap_s;
  logic          flush_s;
  logic [DW-1:0] xp_s;
  logic [SW-1:0] sum_next_s;
  logic signed [PW-1:0] prod_s;

  logic [L-1:0]  cnt_r;
  logic [DW-1:0] mean_prev_r;
  logic [SW-1:0] raw_sum_r;
  logic [DW-1:0] frame_mean_r;
  logic          s1_last_r;

  logic [PW-1:0] sq_r;
  logic          cross_r;
  logic          prev_sign_r;
  logic          s2_vld_r;
  logic          s2_last_r;

  logic [EW-1:0] energy_acc_r;
  logic [ZW-1:0] zcr_acc_r;
  logic          s3_last_r;

  state_t        state_r;
  state_t        state_nxt;
  logic          close_s;

  assign sel_vld_s  = (CHANNEL == 0) ? i_left_vld  : i_right_vld;
  assign sel_data_s = (CHANNEL == 0) ? i_left_data : i_right_data;
  assign flush_s    = ~i_sys_rst | i_clear;
  assign acc_s      = sel_vld_s & ~i_clear;
  assign wrap_s     = (cnt_r == {L{1'b1}});
  assign xp_s       = sat_sub(sel_data_s, mean_prev_r);
  assign sum_next_s = raw_sum_r + {{L{sel_data_s[DW-1]}}, sel_data_s};
  assign prod_s     = $signed({{DW{o_sample[DW-1]}}, o_sample}) *
                      $signed({{DW{o_sample[DW-1]}}, o_sample});

  // Stage 1: DC removal, sample counter and raw-sum accumulation
  always_ff @(posedge i_sys_clk) begin
    if (flush_s) begin
      o_sample     <= '0;
      o_sample_vld <= 1'b0;
      s1_last_r    <= 1'b0;
      cnt_r        <= '0;
      raw_sum_r    <= '0;
      frame_mean_r <= '0;
    end else if (acc_s) begin
      o_sample     <= xp_s;
      o_sample_vld <= 1'b1;
      s1_last_r    <= wrap_s;
      cnt_r        <= cnt_r + {{(L-1){1'b0}}, 1'b1};
      if (wrap_s) begin
        // Frame sum is complete with this sample; latch its mean and restart.
        frame_mean_r <= sum_next_s[SW-1:L];
        raw_sum_r    <= '0;
      end else begin
        raw_sum_r    <= sum_next_s;
      end
    end else begin
      o_sample_vld <= 1'b0;
      s1_last_r    <= 1'b0;
    end
  end

  // Stage 2: square and zero-crossing detection; the sign history spans frames
  always_ff @(posedge i_sys_clk) begin
    if (flush_s) begin
      sq_r        <= '0;
      cross_r     <= 1'b0;
      prev_sign_r <= 1'b0;
      s2_vld_r    <= 1'b0;
      s2_last_r   <= 1'b0;
    end else if (o_sample_vld) begin
      sq_r        <= prod_s;
      cross_r     <= (o_sample[DW-1] != prev_sign_r);
      prev_sign_r <= o_sample[DW-1];
      s2_vld_r    <= 1'b1;
      s2_last_r   <= s1_last_r;
    end else begin
      s2_vld_r    <= 1'b0;
      s2_last_r   <= 1'b0;
    end
  end

  // Stage 3: energy and crossing accumulation, restarting with the in-flight sample at close
  always_ff @(posedge i_sys_clk) begin
    if (flush_s) begin
      energy_acc_r <= '0;
      zcr_acc_r    <= '0;
      s3_last_r    <= 1'b0;
    end else begin
      s3_last_r <= s2_vld_r & s2_last_r;
      if (close_s) begin
        energy_acc_r <= s2_vld_r ? {{L{1'b0}}, sq_r} : '0;
        zcr_acc_r    <= s2_vld_r ? {{L{1'b0}}, cross_r} : '0;
      end else if (s2_vld_r) begin
        energy_acc_r <= energy_acc_r + {{L{1'b0}}, sq_r};
        zcr_acc_r    <= zcr_acc_r + {{L{1'b0}}, cross_r};
      end else begin
        energy_acc_r <= energy_acc_r;
        zcr_acc_r    <= zcr_acc_r;
      end
    end
  end

  // Frame results and the mean used for DC removal of the next frame
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      o_zcr       <= '0;
      o_ste       <= '0;
      o_mean      <= '0;
      o_frame_vld <= 1'b0;
      mean_prev_r <= '0;
    end else if (i_clear) begin
      // Published results survive a clear; everything else restarts.
      o_frame_vld <= 1'b0;
      mean_prev_r <= '0;
    end else if (close_s) begin
      o_zcr       <= zcr_acc_r;
      o_ste       <= sat_ste(energy_acc_r);
      o_mean      <= frame_mean_r;
      o_frame_vld <= 1'b1;
      mean_prev_r <= frame_mean_r;
    end else begin
      o_frame_vld <= 1'b0;
    end
  end

  // Frame-progress state register
  always_ff @(posedge i_sys_clk) begin
    if (flush_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Frame-progress next state; the close event is only honoured in CLOSE
  always_comb begin
    state_nxt = state_r;
    close_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          state_nxt = wrap_s ? ST_CLOSE : ST_ACC;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (acc_s && wrap_s) begin
          state_nxt = ST_CLOSE;
        end else begin
          state_nxt = ST_ACC;
        end
      end
      ST_CLOSE: begin
        if (s3_last_r) begin
          close_s   = 1'b1;
          state_nxt = (acc_s || (cnt_r != {L{1'b0}})) ? ST_ACC : ST_IDLE;
        end else begin
          state_nxt = ST_CLOSE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2s_frame_feature.sv
// Directed bench for i2s_frame_feature with 8-sample frames and no energy shift.
// Two instances share the inputs: dut0 listens to the left channel, dut1 to the right.
module tb_i2s_frame_feature;

  localparam logic [15:0] POS = 16'd100;
  localparam logic [15:0] NEG = 16'hFF9C;   // -100

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        lvld = 1'b0;
  logic        rvld = 1'b0;
  logic [15:0] ldat = 16'd0;
  logic [15:0] rdat = 16'd0;

  logic [15:0] s0, m0, s1, m1;
  logic        sv0, fv0, sv1, fv1;
  logic [3:0]  z0, z1;
  logic [31:0] e0, e1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fv0_cnt = 0, sv0_cnt = 0, fv1_cnt = 0, sv1_cnt = 0;
  int fv1_t_prev = 0, fv1_t_last = 0;

  always #5 clk = ~clk;

  i2s_frame_feature #(.DATA_WIDTH(16), .FRAME_LEN_LOG2(3), .ENERGY_SHIFT(0), .CHANNEL(0)) dut0 (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_left_data(ldat), .i_right_data(rdat), .i_left_vld(lvld), .i_right_vld(rvld),
    .i_clear(clear),
    .o_sample(s0), .o_sample_vld(sv0), .o_zcr(z0), .o_ste(e0), .o_mean(m0), .o_frame_vld(fv0)
  );

  i2s_frame_feature #(.DATA_WIDTH(16), .FRAME_LEN_LOG2(3), .ENERGY_SHIFT(0), .CHANNEL(1)) dut1 (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_left_data(ldat), .i_right_data(rdat), .i_left_vld(lvld), .i_right_vld(rvld),
    .i_clear(clear),
    .o_sample(s1), .o_sample_vld(sv1), .o_zcr(z1), .o_ste(e1), .o_mean(m1), .o_frame_vld(fv1)
  );

  // Cycle counter for strobe spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (fv0) fv0_cnt <= fv0_cnt + 1;
    if (sv0) sv0_cnt <= sv0_cnt + 1;
    if (sv1) sv1_cnt <= sv1_cnt + 1;
    if (fv1) begin
      fv1_cnt    <= fv1_cnt + 1;
      fv1_t_prev <= fv1_t_last;
      fv1_t_last <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; lvld = 1'b0; rvld = 1'b0; clear = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_sample", 64'(s0), 64'd0);
    chk("rst_sample_vld", 64'(sv0), 64'd0);
    chk("rst_zcr", 64'(z0), 64'd0);
    chk("rst_ste", 64'(e0), 64'd0);
    chk("rst_mean", 64'(m0), 64'd0);
    chk("rst_frame_vld", 64'(fv0), 64'd0);
    chk("rst_frame_vld1", 64'(fv1), 64'd0);
    rst = 1'b1;
  endtask

  // Present one left sample at a negedge; return at the next negedge and check stage 1.
  task automatic send_l(input logic [15:0] d, input logic [15:0] exp_xp);
    ldat = d; lvld = 1'b1;
    @(negedge clk);
    lvld = 1'b0;
    chk("sample_vld", 64'(sv0), 64'd1);
    chk("sample", 64'(s0), 64'(exp_xp));
  endtask

  task automatic send_r(input logic [15:0] d);
    rdat = d; rvld = 1'b1;
    @(negedge clk);
    rvld = 1'b0;
  endtask

  // Called right after the last sample of a frame: strobe must arrive exactly 3 cycles later.
  task automatic wait_frame(input logic [3:0] zcr, input logic [31:0] ste, input logic [15:0] mean);
    chk("frame_vld_early0", 64'(fv0), 64'd0);
    @(negedge clk);
    chk("sample_vld_drop", 64'(sv0), 64'd0);
    chk("frame_vld_early1", 64'(fv0), 64'd0);
    @(negedge clk);
    chk("frame_vld_early2", 64'(fv0), 64'd0);
    @(negedge clk);
    chk("frame_vld", 64'(fv0), 64'd1);
    chk("zcr", 64'(z0), 64'(zcr));
    chk("ste", 64'(e0), 64'(ste));
    chk("mean", 64'(m0), 64'(mean));
    @(negedge clk);
    chk("frame_vld_pulse", 64'(fv0), 64'd0);
    chk("zcr_hold", 64'(z0), 64'(zcr));
  endtask

  int base_a;
  int base_b;

  initial begin
    @(negedge clk);

    // Reset state
    do_reset();

    // Alternating +/-100
    for (int i = 0; i < 8; i++) send_l((i % 2 == 0) ? POS : NEG, (i % 2 == 0) ? POS : NEG);
    wait_frame(4'd7, 32'd80000, 16'd0);

    // Constant 1000: second frame removes the DC fully
    do_reset();
    for (int i = 0; i < 8; i++) send_l(16'd1000, 16'd1000);
    wait_frame(4'd0, 32'd8000000, 16'd1000);
    for (int i = 0; i < 8; i++) send_l(16'd1000, 16'd0);
    wait_frame(4'd0, 32'd0, 16'd1000);

    // Full-scale negative then positive: energy and difference saturation
    do_reset();
    for (int i = 0; i < 8; i++) send_l(16'h8000, 16'h8000);
    wait_frame(4'd1, 32'hFFFFFFFF, 16'h8000);
    for (int i = 0; i < 8; i++) send_l(16'h7FFF, 16'h7FFF);
    wait_frame(4'd1, 32'hFFFFFFFF, 16'h7FFF);

    // Clear mid-frame with a coincident strobe; results from before must hold
    @(negedge clk);
    base_a = fv0_cnt;
    for (int i = 0; i < 5; i++) begin
      ldat = (i % 2 == 0) ? POS : NEG; lvld = 1'b1;
      @(negedge clk);
    end
    ldat = POS; lvld = 1'b1; clear = 1'b1;
    @(negedge clk);
    lvld = 1'b0; clear = 1'b0;
    chk("clr_sample_vld", 64'(sv0), 64'd0);
    chk("clr_sample", 64'(s0), 64'd0);
    chk("clr_zcr_hold", 64'(z0), 64'd1);
    chk("clr_ste_hold", 64'(e0), 64'hFFFFFFFF);
    chk("clr_mean_hold", 64'(m0), 64'h7FFF);
    repeat (4) @(negedge clk);
    chk("clr_no_partial_frame", 64'(fv0_cnt - base_a), 64'd0);
    for (int i = 0; i < 8; i++) send_l((i % 2 == 0) ? POS : NEG, (i % 2 == 0) ? POS : NEG);
    wait_frame(4'd7, 32'd80000, 16'd0);
    repeat (2) @(negedge clk);
    chk("clr_frame_count", 64'(fv0_cnt - base_a), 64'd1);

    // Right-channel strobes are ignored by the left-channel instance
    do_reset();
    base_a = sv0_cnt;
    for (int i = 0; i < 4; i++) send_r(16'd1234);
    repeat (3) @(negedge clk);
    chk("right_ignored", 64'(sv0_cnt - base_a), 64'd0);

    // Right-channel instance, 16 back-to-back samples of 500
    do_reset();
    base_a = fv1_cnt;
    base_b = sv1_cnt;
    for (int i = 0; i < 16; i++) send_r(16'd500);
    repeat (8) @(negedge clk);
    chk("ch1_frame_count", 64'(fv1_cnt - base_a), 64'd2);
    chk("ch1_frame_spacing", 64'(fv1_t_last - fv1_t_prev), 64'd8);
    chk("ch1_sample_count", 64'(sv1_cnt - base_b), 64'd16);
    // Samples 9-11 fall in the close window and still see mean 0.
    chk("ch1_ste", 64'(e1), 64'd750000);
    chk("ch1_mean", 64'(m1), 64'd500);
    chk("ch1_zcr", 64'(z1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
